// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern engine.
//   - MODE_* : 3-bit animation mode encodings (6 and 7 behave as HOLD)
//   - MAX_WIDTH / MAX_STEP_DIV : legal parameter ceilings, also used to size
//     the position and prescaler counters
package led_pattern_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'd0;
  localparam logic [2:0] MODE_ROT_L = 3'd1;
  localparam logic [2:0] MODE_ROT_R = 3'd2;
  localparam logic [2:0] MODE_PING  = 3'd3;
  localparam logic [2:0] MODE_BAR   = 3'd4;
  localparam logic [2:0] MODE_BLINK = 3'd5;

  localparam int MAX_WIDTH    = 32;
  localparam int MAX_STEP_DIV = 255;

endpackage

// File: rtl/led_pattern_engine_step_prescaler.sv
// Step prescaler: counts enabled clk_2hz edges and flags the edge on which an
// animation step is due.
//   clk_2hz, rst : clock, async active-high reset
//   enable       : count only when high; low freezes the count
//   clear        : synchronous clear (mode change / accepted load)
//   tick         : high when the step falls on the coming edge
// tick is a decode of the registered count, so the step lands on the same
// edge where the count wraps; every enabled edge ticks when STEP_DIV=1.
module step_prescaler
  import led_pattern_pkg::*;
#(
  parameter int STEP_DIV = 1
) (
  input  logic clk_2hz,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int PW = $clog2(MAX_STEP_DIV + 1);
  localparam logic [PW-1:0] LIM = PW'(STEP_DIV - 1);

  logic [PW-1:0] presc;

  assign tick = enable && (presc == LIM);

  always_ff @(posedge clk_2hz or posedge rst) begin
    if (rst)         presc <= '0;
    else if (clear)  presc <= '0;
    else if (tick)   presc <= '0;
    else if (enable) presc <= presc + PW'(1);
  end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: WIDTH-bit LED sequencer on the 2 Hz clock.
//   clk_2hz, rst : clock, async active-high reset
//   enable       : run; low freezes all animation state
//   mode         : 0 HOLD, 1 ROT_L, 2 ROT_R, 3 PING, 4 BAR, 5 BLINK (6/7 = HOLD)
//   load         : load load_value into led (HOLD/ROT/BLINK only)
//   led          : registered LED drive
//   step / wrap  : one-cycle pulses on each step / on cycle completion
// Per-edge priority: reset, mode change, load, step.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int          WIDTH        = 16,
  parameter logic [31:0] INIT_PATTERN = 32'h5555,
  parameter int          STEP_DIV     = 1
) (
  input  logic             clk_2hz,
  input  logic             rst,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] led,
  output logic             step,
  output logic             wrap
);

  localparam int PW = $clog2(MAX_WIDTH + 1);
  localparam logic [WIDTH-1:0] SEED = INIT_PATTERN[WIDTH-1:0];
  localparam logic [PW-1:0]    TOP  = PW'(WIDTH);
  localparam logic [PW-1:0]    LAST = PW'(WIDTH - 1);

  logic [2:0]    mode_q;
  logic [PW-1:0] pos, rot_cnt;
  logic          dir;

  logic             mode_chg, load_acc, tick;
  logic [PW-1:0]    ping_pos, bar_pos, rot_nxt;
  logic [WIDTH-1:0] ping_led, bar_led, seed_led;

  assign mode_chg = (mode != mode_q);
  // PING and BAR own their LED image, so loads are dropped there.
  assign load_acc = load && !mode_chg &&
                    !(mode_q == MODE_PING || mode_q == MODE_BAR);

  step_prescaler #(.STEP_DIV(STEP_DIV)) u_presc (
    .clk_2hz (clk_2hz),
    .rst     (rst),
    .enable  (enable),
    .clear   (mode_chg || load_acc),
    .tick    (tick)
  );

  always_comb begin
    rot_nxt  = rot_cnt + PW'(1);
    ping_pos = dir ? pos + PW'(1) : pos - PW'(1);
    bar_pos  = (pos == TOP) ? '0 : pos + PW'(1);
    ping_led = '0;
    bar_led  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ping_led[i] = (PW'(i) == ping_pos);
      bar_led[i]  = (PW'(i) <  bar_pos);
    end
    case (mode)
      MODE_ROT_L, MODE_ROT_R, MODE_BLINK: seed_led = SEED;
      MODE_PING:                          seed_led = WIDTH'(1);
      MODE_BAR:                           seed_led = '0;
      default:                            seed_led = led;
    endcase
  end

  always_ff @(posedge clk_2hz or posedge rst) begin
    if (rst) begin
      led     <= SEED;
      mode_q  <= MODE_HOLD;
      pos     <= '0;
      dir     <= 1'b1;
      rot_cnt <= '0;
      step    <= 1'b0;
      wrap    <= 1'b0;
    end else if (mode_chg) begin
      mode_q  <= mode;
      led     <= seed_led;
      pos     <= '0;
      dir     <= 1'b1;
      rot_cnt <= '0;
      step    <= 1'b0;
      wrap    <= 1'b0;
    end else if (load_acc) begin
      led     <= load_value;
      rot_cnt <= '0;
      step    <= 1'b0;
      wrap    <= 1'b0;
    end else if (tick) begin
      step <= 1'b1;
      wrap <= 1'b0;
      case (mode_q)
        MODE_ROT_L, MODE_ROT_R: begin
          led <= (mode_q == MODE_ROT_L) ? {led[WIDTH-2:0], led[WIDTH-1]}
                                        : {led[0], led[WIDTH-1:1]};
          if (rot_nxt == TOP) begin
            rot_cnt <= '0;
            wrap    <= 1'b1;
          end else begin
            rot_cnt <= rot_nxt;
          end
        end
        MODE_PING: begin
          pos <= ping_pos;
          led <= ping_led;
          if (ping_pos == LAST) dir <= 1'b0;
          if (ping_pos == '0) begin
            dir  <= 1'b1;
            wrap <= 1'b1;
          end
        end
        MODE_BAR: begin
          pos  <= bar_pos;
          led  <= bar_led;
          wrap <= (bar_pos == '0);
        end
        MODE_BLINK: begin
          // rot_cnt[0] marks odd steps; the even one closes the cycle.
          led     <= ~led;
          rot_cnt <= rot_cnt ^ PW'(1);
          wrap    <= rot_cnt[0];
        end
        default: ;
      endcase
    end else begin
      step <= 1'b0;
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_pattern_engine.sv
module tb_led_pattern_engine;

  logic clk_2hz = 1'b0;
  logic rst;
  always #5 clk_2hz = ~clk_2hz;

  int errors = 0;
  int checks = 0;

  // a: WIDTH 16, seed 5555, STEP_DIV 1
  logic        en_a, load_a, step_a, wrap_a;
  logic [2:0]  mode_a;
  logic [15:0] lv_a, led_a;
  // b: WIDTH 16, seed 0001, STEP_DIV 3
  logic        en_b, load_b, step_b, wrap_b;
  logic [2:0]  mode_b;
  logic [15:0] lv_b, led_b;
  // c: WIDTH 4, seed 5555 -> 5, STEP_DIV 1
  logic        en_c, load_c, step_c, wrap_c;
  logic [2:0]  mode_c;
  logic [3:0]  lv_c, led_c;

  led_pattern_engine #(.WIDTH(16), .INIT_PATTERN(32'h5555), .STEP_DIV(1)) u_a (
    .clk_2hz(clk_2hz), .rst(rst), .enable(en_a), .mode(mode_a), .load(load_a),
    .load_value(lv_a), .led(led_a), .step(step_a), .wrap(wrap_a));
  led_pattern_engine #(.WIDTH(16), .INIT_PATTERN(32'h0001), .STEP_DIV(3)) u_b (
    .clk_2hz(clk_2hz), .rst(rst), .enable(en_b), .mode(mode_b), .load(load_b),
    .load_value(lv_b), .led(led_b), .step(step_b), .wrap(wrap_b));
  led_pattern_engine #(.WIDTH(4), .INIT_PATTERN(32'h5555), .STEP_DIV(1)) u_c (
    .clk_2hz(clk_2hz), .rst(rst), .enable(en_c), .mode(mode_c), .load(load_c),
    .load_value(lv_c), .led(led_c), .step(step_c), .wrap(wrap_c));

  task automatic edge1();
    @(posedge clk_2hz);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en_a = 1'b1; mode_a = 3'd1; load_a = 1'b0; lv_a = '0;
    en_b = 1'b1; mode_b = 3'd0; load_b = 1'b0; lv_b = '0;
    en_c = 1'b1; mode_c = 3'd0; load_c = 1'b0; lv_c = '0;
    edge1(); edge1();
    checks++; if (led_a !== 16'h5555) begin errors++; $display("FAIL reset_led_a: got %h expected 5555", led_a); end
    checks++; if (led_b !== 16'h0001) begin errors++; $display("FAIL reset_led_b: got %h expected 0001", led_b); end
    checks++; if (led_c !== 4'h5) begin errors++; $display("FAIL reset_led_c: got %h expected 5", led_c); end
    checks++; if (step_a !== 1'b0 || wrap_a !== 1'b0) begin errors++; $display("FAIL reset_step_wrap: got %b%b expected 00", step_a, wrap_a); end
    rst = 1'b0;
  endtask

  task automatic test_rot_l();
    logic [15:0] exp_led;
    edge1();  // mode change edge (mode_q 0 -> 1)
    checks++; if (led_a !== 16'h5555 || step_a !== 1'b0) begin errors++; $display("FAIL rotl_modechg: got led=%h step=%b expected 5555/0", led_a, step_a); end
    for (int k = 1; k <= 16; k++) begin
      edge1();
      exp_led = (k % 2 == 1) ? 16'hAAAA : 16'h5555;
      checks++; if (led_a !== exp_led) begin errors++; $display("FAIL rotl_led step %0d: got %h expected %h", k, led_a, exp_led); end
      checks++; if (step_a !== 1'b1) begin errors++; $display("FAIL rotl_step step %0d: got %b expected 1", k, step_a); end
      checks++; if (wrap_a !== (k == 16)) begin errors++; $display("FAIL rotl_wrap step %0d: got %b expected %b", k, wrap_a, (k == 16)); end
    end
  endtask

  task automatic test_prescaler_pause();
    mode_b = 3'd2;
    edge1();  // mode change, seed 0001
    checks++; if (led_b !== 16'h0001 || step_b !== 1'b0) begin errors++; $display("FAIL presc_seed: got %h/%b expected 0001/0", led_b, step_b); end
    edge1(); edge1();
    checks++; if (led_b !== 16'h0001 || step_b !== 1'b0) begin errors++; $display("FAIL presc_early: got %h/%b expected 0001/0", led_b, step_b); end
    edge1();
    checks++; if (led_b !== 16'h8000 || step_b !== 1'b1) begin errors++; $display("FAIL presc_step1: got %h/%b expected 8000/1", led_b, step_b); end
    edge1();  // one enabled edge toward the next step
    en_b = 1'b0;
    for (int k = 0; k < 5; k++) begin
      edge1();
      checks++; if (led_b !== 16'h8000 || step_b !== 1'b0) begin errors++; $display("FAIL pause_frozen edge %0d: got %h/%b expected 8000/0", k, led_b, step_b); end
    end
    en_b = 1'b1;
    edge1();
    checks++; if (led_b !== 16'h8000 || step_b !== 1'b0) begin errors++; $display("FAIL resume_early: got %h/%b expected 8000/0", led_b, step_b); end
    edge1();
    checks++; if (led_b !== 16'h4000 || step_b !== 1'b1) begin errors++; $display("FAIL resume_step: got %h/%b expected 4000/1", led_b, step_b); end
  endtask

  task automatic test_ping();
    logic [3:0] seq [6] = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1};
    mode_c = 3'd3;
    edge1();
    checks++; if (led_c !== 4'h1 || step_c !== 1'b0) begin errors++; $display("FAIL ping_seed: got %h/%b expected 1/0", led_c, step_c); end
    for (int k = 0; k < 6; k++) begin
      edge1();
      checks++; if (led_c !== seq[k]) begin errors++; $display("FAIL ping_led step %0d: got %h expected %h", k + 1, led_c, seq[k]); end
      checks++; if (wrap_c !== (k == 5)) begin errors++; $display("FAIL ping_wrap step %0d: got %b expected %b", k + 1, wrap_c, (k == 5)); end
    end
  endtask

  task automatic test_bar_mode_change();
    logic [3:0] seq [8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'h0, 4'h1, 4'h3, 4'h7};
    mode_c = 3'd4;
    edge1();
    checks++; if (led_c !== 4'h0 || step_c !== 1'b0) begin errors++; $display("FAIL bar_seed: got %h/%b expected 0/0", led_c, step_c); end
    for (int k = 0; k < 8; k++) begin
      edge1();
      checks++; if (led_c !== seq[k]) begin errors++; $display("FAIL bar_led step %0d: got %h expected %h", k + 1, led_c, seq[k]); end
      checks++; if (wrap_c !== (k == 4)) begin errors++; $display("FAIL bar_wrap step %0d: got %b expected %b", k + 1, wrap_c, (k == 4)); end
    end
    mode_c = 3'd5;
    edge1();
    checks++; if (led_c !== 4'h5 || step_c !== 1'b0 || wrap_c !== 1'b0) begin errors++; $display("FAIL blink_seed: got %h/%b%b expected 5/00", led_c, step_c, wrap_c); end
    edge1();
    checks++; if (led_c !== 4'hA || step_c !== 1'b1 || wrap_c !== 1'b0) begin errors++; $display("FAIL blink_1: got %h/%b%b expected A/10", led_c, step_c, wrap_c); end
    edge1();
    checks++; if (led_c !== 4'h5 || step_c !== 1'b1 || wrap_c !== 1'b1) begin errors++; $display("FAIL blink_2: got %h/%b%b expected 5/11", led_c, step_c, wrap_c); end
  endtask

  task automatic test_load_priority();
    load_a = 1'b1; lv_a = 16'h00F0;
    edge1();
    checks++; if (led_a !== 16'h00F0 || step_a !== 1'b0) begin errors++; $display("FAIL load_rotl: got %h/%b expected 00F0/0", led_a, step_a); end
    load_a = 1'b0;
    edge1();
    checks++; if (led_a !== 16'h01E0 || step_a !== 1'b1) begin errors++; $display("FAIL load_then_rot: got %h/%b expected 01E0/1", led_a, step_a); end
    mode_a = 3'd3;
    edge1();
    checks++; if (led_a !== 16'h0001) begin errors++; $display("FAIL ping_seed_a: got %h expected 0001", led_a); end
    load_a = 1'b1;
    edge1();
    checks++; if (led_a !== 16'h0002 || step_a !== 1'b1) begin errors++; $display("FAIL load_ignored_ping: got %h/%b expected 0002/1", led_a, step_a); end
    load_a = 1'b0;
  endtask

  task automatic test_async_reset();
    mode_a = 3'd4;
    edge1();
    for (int k = 0; k < 9; k++) edge1();
    checks++; if (led_a !== 16'h01FF || step_a !== 1'b1) begin errors++; $display("FAIL bar_pos9: got %h/%b expected 01FF/1", led_a, step_a); end
    #2 rst = 1'b1;
    #1;
    checks++; if (led_a !== 16'h5555) begin errors++; $display("FAIL async_led: got %h expected 5555", led_a); end
    checks++; if (step_a !== 1'b0 || wrap_a !== 1'b0) begin errors++; $display("FAIL async_step_wrap: got %b%b expected 00", step_a, wrap_a); end
    checks++; if (u_a.mode_q !== 3'd0) begin errors++; $display("FAIL async_mode_q: got %0d expected 0", u_a.mode_q); end
    edge1();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rot_l();
    test_prescaler_pause();
    test_ping();
    test_bar_mode_change();
    test_load_priority();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
